// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyfilt_pkg.sv
// Shared constants and helpers for the delay-cell deglitch filter.
//   DLYFILT_SYNC_STAGES : default synchroniser depth
//   DLYFILT_CNT_W       : default stability counter / threshold width
//   dlyfilt_the()       : threshold normalisation (a zero threshold behaves as one)
package gf180mcu_fd_sc_mcu9t5v0__dlyfilt_pkg;

  localparam int unsigned DLYFILT_SYNC_STAGES = 2;
  localparam int unsigned DLYFILT_CNT_W       = 4;

  // Effective threshold: TH=0 would otherwise commit with no stable samples at all.
  function automatic logic [31:0] dlyfilt_the(input logic [31:0] th);
    return (th == 32'd0) ? 32'd1 : th;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyfilt_sync.sv
// Multi-flop synchroniser for the asynchronous delay-cell output.
//   clk_i : rising-edge clock
//   rst_i : synchronous active-high reset, clears every stage
//   d_i   : asynchronous input (only stage 0 samples it)
//   q_o   : synchronised output, last stage of the chain
module gf180mcu_fd_sc_mcu9t5v0__dlyfilt_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] s_q;
  logic [Stages-1:0] s_d;

  always_comb begin
    s_d = {s_q[Stages-2:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign q_o = s_q[Stages-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyfilt_1.sv
// Clocked deglitch filter fed by the 9-track delay cell output.
//   CLK  : rising-edge clock
//   RST  : synchronous active-high reset, overrides all other inputs
//   EN   : filter enable; when low the counter clears and Z holds
//   I    : asynchronous input (delay cell Z)
//   TH   : consecutive differing samples needed to commit (0 acts as 1)
//   Z    : filtered level
//   ZR   : one-cycle pulse after a committed rise
//   ZF   : one-cycle pulse after a committed fall
//   BUSY : a candidate transition is being counted
//   VDD/VSS : supply pins, no functional effect
module gf180mcu_fd_sc_mcu9t5v0__dlyfilt_1
  import gf180mcu_fd_sc_mcu9t5v0__dlyfilt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DLYFILT_SYNC_STAGES,
  parameter int unsigned CNT_W       = DLYFILT_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             I,
  input  logic [CNT_W-1:0] TH,
  output logic             Z,
  output logic             ZR,
  output logic             ZF,
  output logic             BUSY,
  inout  wire              VDD,
  inout  wire              VSS
);

  logic             s_sync;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             zr_q, zr_d;
  logic             zf_q, zf_d;
  logic [CNT_W:0]   th_eff;
  logic [CNT_W:0]   cnt_p1;

  // Supplies are pins only in this functional view.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  gf180mcu_fd_sc_mcu9t5v0__dlyfilt_sync #(
    .Stages(SYNC_STAGES)
  ) u_sync (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (I),
    .q_o  (s_sync)
  );

  always_comb begin
    th_eff = (CNT_W+1)'(dlyfilt_the(32'(TH)));
    // One extra bit so cnt+1 cannot wrap before the compare.
    cnt_p1 = {1'b0, cnt_q} + (CNT_W+1)'(1);

    cnt_d = cnt_q;
    z_d   = z_q;
    zr_d  = 1'b0;
    zf_d  = 1'b0;

    if (!EN) begin
      cnt_d = '0;
    end else if (s_sync == z_q) begin
      // Input returned to the committed level: discard any partial count.
      cnt_d = '0;
    end else if (cnt_p1 >= th_eff) begin
      z_d   = s_sync;
      cnt_d = '0;
      zr_d  = s_sync;
      zf_d  = ~s_sync;
    end else begin
      cnt_d = cnt_p1[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      z_q   <= 1'b0;
      zr_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      z_q   <= z_d;
      zr_q  <= zr_d;
      zf_q  <= zf_d;
    end
  end

  assign Z    = z_q;
  assign ZR   = zr_q;
  assign ZF   = zf_q;
  assign BUSY = (cnt_q != '0);

`ifdef GF180MCU_DLYFILT_TIMING
  specify
    (posedge CLK => (Z    +: I)) = (0.0, 0.0);
    (posedge CLK => (ZR   +: I)) = (0.0, 0.0);
    (posedge CLK => (ZF   +: I)) = (0.0, 0.0);
    (posedge CLK => (BUSY +: I)) = (0.0, 0.0);
    $setuphold(posedge CLK, RST, 0.0, 0.0);
    $setuphold(posedge CLK, EN,  0.0, 0.0);
    $setuphold(posedge CLK, TH,  0.0, 0.0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlyfilt_1.sv
module tb_gf180mcu_fd_sc_mcu9t5v0__dlyfilt_1;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned CntW       = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic            i_in = 1'b0;
  logic [CntW-1:0] th = '0;
  logic            z, zr, zf, busy;
  wire             vdd;
  wire             vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int checks   = 0;
  int failures = 0;

  gf180mcu_fd_sc_mcu9t5v0__dlyfilt_1 #(
    .SYNC_STAGES(SyncStages),
    .CNT_W      (CntW)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .EN  (en),
    .I   (i_in),
    .TH  (th),
    .Z   (z),
    .ZR  (zr),
    .ZF  (zf),
    .BUSY(busy),
    .VDD (vdd),
    .VSS (vss)
  );

  always #5 clk = ~clk;

  // Reference model: history of sampled inputs plus a run length of
  // consecutive samples that disagree with the committed level.
  bit m_hist[$];
  bit m_z, m_zr, m_zf;
  int m_run;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit iv, input int t);
    bit s;
    int the;
    if (r) begin
      m_hist.delete();
      for (int k = 0; k < SyncStages; k++) m_hist.push_back(1'b0);
      m_z = 0; m_zr = 0; m_zf = 0; m_run = 0;
      return;
    end
    s = m_hist[SyncStages-1];  // input seen SyncStages edges ago
    m_hist.push_front(iv);
    void'(m_hist.pop_back());
    the = (t == 0) ? 1 : t;
    m_zr = 0;
    m_zf = 0;
    if (!e || s == m_z) begin
      m_run = 0;
    end else if (m_run + 1 >= the) begin
      m_z = s; m_zr = s; m_zf = !s; m_run = 0;
    end else begin
      m_run++;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit iv, input int t);
    @(negedge clk);
    rst = r; en = e; i_in = iv; th = CntW'(t);
    @(posedge clk);
    model_step(r, e, iv, t);
    #1;
    check_val("z",    32'(z),    32'(m_z));
    check_val("zr",   32'(zr),   32'(m_zr));
    check_val("zf",   32'(zf),   32'(m_zf));
    check_val("busy", 32'(busy), 32'(m_run != 0));
  endtask

  initial begin
    bit cur_i;
    int cur_th;
    for (int k = 0; k < SyncStages; k++) m_hist.push_back(1'b0);

    // Reset with I high, then TH=3 step: rise at edge 5 after release.
    cycle(1, 1, 1, 3);
    cycle(1, 1, 1, 3);
    check_val("reset_z", 32'(z), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 1, 3);
    check_val("step_z_before", 32'(z), 32'd0);
    cycle(0, 1, 1, 3);
    check_val("step_z_edge5", 32'(z), 32'd1);
    check_val("step_zr_edge5", 32'(zr), 32'd1);
    cycle(0, 1, 1, 3);
    check_val("step_zr_single", 32'(zr), 32'd0);

    // Back to 0, then glitch of 3 samples against TH=4.
    for (int k = 0; k < 8; k++) cycle(0, 1, 0, 1);
    for (int k = 0; k < 3; k++) cycle(0, 1, 1, 4);
    for (int k = 0; k < 6; k++) cycle(0, 1, 0, 4);
    check_val("glitch_z", 32'(z), 32'd0);

    // TH=0 and TH=1 steps.
    for (int k = 0; k < 5; k++) cycle(0, 1, 1, 0);
    for (int k = 0; k < 5; k++) cycle(0, 1, 0, 1);

    // TH lowered mid-count.
    for (int k = 0; k < 7; k++) cycle(0, 1, 1, 8);
    for (int k = 0; k < 3; k++) cycle(0, 1, 1, 3);
    check_val("thdrop_z", 32'(z), 32'd1);

    // EN gating, then enable with S!=Z and TH=2.
    for (int k = 0; k < 6; k++) cycle(0, 0, k[0], 2);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 2);
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 2);

    // Reset mid-count during a fall.
    for (int k = 0; k < 6; k++) cycle(0, 1, 1, 1);
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 6);
    cycle(1, 1, 0, 6);
    check_val("rstmid_z", 32'(z), 32'd0);
    check_val("rstmid_zf", 32'(zf), 32'd0);

    // Randomised run.
    cur_i = 0;
    cur_th = 2;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) cur_i = !cur_i;
      if ($urandom_range(0, 15) == 0) cur_th = $urandom_range(0, 5);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) != 0), cur_i, cur_th);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
